mt9v034_capture_ctrl: RTL and testbench
=======================================

# mt9v034_capture_ctrl

Frame capture sequencer placed directly after the MT9V034 embedded-sync detector and ahead of the pixel packer/DMA. Software arms single-shot or continuous capture. The block then does four things:
- aligns capture to a clean frame start;
- crops the pixel stream to the configured width and height;
- generates start-of-frame, end-of-line and end-of-frame markers in the same cycle as the pixel they mark;
- reports per-frame statistics and geometry errors.

## Interface
Parameters:
- `W_BITS`, default 10: width of column counters and `cfg_width`.
- `H_BITS`, default 10: width of row counters and `cfg_height`.

Ports:
- `pxclk` in 1: pixel clock. This is the block's only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that arms capture. Honoured only in IDLE.
- `stop` in 1: one-cycle pulse that ends capture.
- `continuous` in 1: sampled in DONE. 1 means re-arm automatically.
- `cfg_width` in W_BITS: pixels per line. Latched on an accepted `start`.
- `cfg_height` in H_BITS: lines per frame. Latched on an accepted `start`.
- `line_valid`, `frame_valid`, `active_video`, `pixel_data_valid` in 1 each: detector outputs.
- `pixel_accept` out 1: the current detector pixel belongs to the captured frame.
- `sof` out 1: first accepted pixel of the frame.
- `eol` out 1: last accepted pixel of a line.
- `eof` out 1: last accepted pixel of the frame.
- `busy` out 1: state is not IDLE.
- `frame_done` out 1: one-cycle pulse, asserted in DONE.
- `frame_count` out 16: frames completed. Wraps from 0xFFFF to 0.
- `last_width` out W_BITS: raw pixel count of the last line of the previous frame.
- `last_height` out H_BITS: line count of the previous frame.
- `err_short_line`, `err_long_line`, `err_height` out 1 each: sticky error flags.

## Operation
- **Qualifying pixel:** `qual = pixel_data_valid & active_video`.
- **FSM states:** IDLE, ARMED, CAPTURE, DONE.
- **IDLE:**
  - `start & !stop` with both cfg values nonzero goes to ARMED. It latches cfg, clears the sticky errors and clears `seen_low`.
  - `start` with a zero cfg value, or `start` together with `stop`, is ignored.
- **ARMED:**
  - `frame_valid == 0` sets `seen_low`.
  - `seen_low & frame_valid` goes to CAPTURE and clears `raw_x` and `y`.
  - `stop` goes to IDLE.
- **CAPTURE:**
  - `raw_x` increments on `qual` and saturates at 2^W_BITS-1.
  - `pixel_accept = qual & (raw_x < cfg_width) & (y < cfg_height)`.
  - `eol = pixel_accept & (raw_x == cfg_width-1)`.
  - `eof = eol & (y == cfg_height-1)`.
  - `sof = pixel_accept & (raw_x == 0) & (y == 0)`.
- **Line end:** a falling edge of `line_valid`, or a falling edge of `frame_valid` while `line_valid_d == 1`.
  - If `raw_x > 0`, `y` increments (saturating) and `last_width` takes `raw_x`.
  - `raw_x` clears.
  - The error checks below are performed.
- **Frame end:** a falling edge of `frame_valid` in CAPTURE goes to DONE. If a line end happens in the same cycle, it is processed first.
- **DONE** (one cycle):
  - `frame_done = 1`.
  - `frame_count` increments.
  - `last_height` takes `y`.
  - Next state is ARMED if `continuous & !stop_pending`, otherwise IDLE. In both cases `seen_low = 1`, because `frame_valid` is already low.
- **stop:** asserting `stop` in CAPTURE or DONE sets `stop_pending`. The frame in progress completes normally. `stop_pending` clears on entry to IDLE.
- **Outside CAPTURE:** the counters hold and all marker outputs are 0.

## Timing
- `pixel_accept`, `sof`, `eol` and `eof` are combinational from the inputs and registered counters. They have zero latency: they are valid in the same cycle as the qualifying pixel.
- All other outputs are registered.
- State change happens one cycle after the triggering input edge.
- `frame_done` asserts 2 cycles after the `frame_valid` falling-edge sample: one cycle for the edge register, one for DONE.
- Edge detection uses `line_valid_d`/`frame_valid_d`, which are registered every cycle.
- Reset values: state IDLE, every output 0, every counter 0, `seen_low = 0`, `stop_pending = 0`.
- Asserting `reset_n` mid-frame aborts immediately. No `frame_done` is produced and `frame_count` is cleared.

## Configuration
Macro `MT9V034_CAPTURE_ERR_EN`.

With the macro defined, the sticky error flags work as follows:
- At each line end with `raw_x > 0`: set `err_short_line` if `raw_x < cfg_width`, and set `err_long_line` if `raw_x > cfg_width`.
- At frame end: set `err_height` if `y != cfg_height`.
- The flags are cleared only by an accepted `start` or by reset.

Without the macro, the three error outputs are tied to 0 and no comparison logic is built. Cropping, markers and statistics are unchanged.

## Test plan
- **Nominal single-shot capture.** Stimulus: `cfg_width=4`, `cfg_height=3`, single-shot; the sensor sends a frame of 3 lines × 4 pixels. Required response:
  - 12 `pixel_accept` cycles, with `sof` on the first and `eol` on pixels 4, 8 and 12;
  - `eof` on pixel 12 only;
  - `frame_done` 2 cycles after `frame_valid` falls;
  - `frame_count` = 1, `last_width` = 4, `last_height` = 3;
  - no error flag set, and the block returns to IDLE.
- **Arming mid-frame.** Stimulus: `start` while `frame_valid` is already 1. Required response: no `pixel_accept` until `frame_valid` has gone low and then high again; the next full frame is captured.
- **Oversize frame, cropped.** Stimulus: `cfg` 4×3; the sensor sends 4 lines × 6 pixels. Required response:
  - only columns 0–3 of lines 0–2 are accepted, 12 pixels in total;
  - `last_width` = 6, `last_height` = 4;
  - with the macro, `err_long_line` = 1 and `err_height` = 1.
- **Short line.** Stimulus: `cfg` 4×3; line 1 carries 3 pixels. Required response:
  - line 1 produces no `eol`, and `eof` still occurs on the last pixel of line 2;
  - with the macro, `err_short_line` = 1 and `err_height` = 0.
- **Continuous mode with stop.** Stimulus: continuous mode; `stop` pulsed during frame 2. Required response:
  - frames 1 and 2 complete and `frame_count` reaches 2;
  - the block goes to IDLE after frame 2 and frame 3 is ignored;
  - a `start` and `stop` pulse in the same cycle while IDLE leaves `busy` = 0.
- **Reset mid-frame.** Stimulus: `reset_n` low for 1 cycle during CAPTURE. Required response: all outputs go to 0 immediately, the state is IDLE and `frame_count` = 0.

Source files
------------

// File: rtl/mt9v034_capture_ctrl.sv
// mt9v034_capture_ctrl
// Frame capture sequencer sitting between the MT9V034 embedded-sync detector
// and the pixel packer/DMA. Software arms single-shot or continuous capture;
// the block aligns to a clean frame start, crops to cfg_width x cfg_height,
// marks sof/eol/eof on the marked pixel itself and keeps per-frame statistics.
//
// Optional feature macro: MT9V034_CAPTURE_ERR_EN
//   defined   -> sticky geometry error flags are built
//   undefined -> err_* outputs are tied to 0
//
// Ports:
//   pxclk, reset_n            pixel clock, async active-low reset
//   start, stop, continuous   software control (start honoured only in IDLE)
//   cfg_width, cfg_height     crop geometry, latched on an accepted start
//   line_valid, frame_valid,
//   active_video,
//   pixel_data_valid          detector outputs
//   pixel_accept, sof, eol,
//   eof                       combinational per-pixel markers (zero latency)
//   busy, frame_done          registered status
//   frame_count, last_width,
//   last_height               registered statistics
//   err_short_line,
//   err_long_line, err_height sticky geometry errors
//   dbg_state                 FSM state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE)
//
// Handshake: there is no backpressure. A pixel is offered whenever
// pixel_data_valid & active_video is high, and pixel_accept says in that same
// cycle whether it belongs to the captured frame.
module mt9v034_capture_ctrl #(
  parameter int W_BITS = 10,
  parameter int H_BITS = 10
) (
  input  logic              pxclk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [W_BITS-1:0] cfg_width,
  input  logic [H_BITS-1:0] cfg_height,
  input  logic              line_valid,
  input  logic              frame_valid,
  input  logic              active_video,
  input  logic              pixel_data_valid,
  output logic              pixel_accept,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [W_BITS-1:0] last_width,
  output logic [H_BITS-1:0] last_height,
  output logic              err_short_line,
  output logic              err_long_line,
  output logic              err_height,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              seen_low_q, seen_low_d;
  logic              stop_pend_q, stop_pend_d;
  logic [W_BITS-1:0] raw_x_q, raw_x_d;
  logic [W_BITS-1:0] cfg_w_q, cfg_w_d;
  logic [W_BITS-1:0] last_w_q, last_w_d;
  logic [H_BITS-1:0] y_q, y_d;
  logic [H_BITS-1:0] cfg_h_q, cfg_h_d;
  logic [H_BITS-1:0] last_h_q, last_h_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              lv_dly_q, fv_dly_q;

  logic qual, in_cap, fv_fall, line_end, frame_end, start_ok;

  assign qual      = pixel_data_valid & active_video;
  assign in_cap    = (state_q == ST_CAPTURE);
  assign fv_fall   = fv_dly_q & ~frame_valid;
  // A line also ends when the frame drops while a line was still open.
  assign line_end  = in_cap & lv_dly_q & (~line_valid | fv_fall);
  assign frame_end = in_cap & fv_fall;
  assign start_ok  = (state_q == ST_IDLE) & start & ~stop &
                     (|cfg_width) & (|cfg_height);

  assign pixel_accept = in_cap & qual & (raw_x_q < cfg_w_q) & (y_q < cfg_h_q);
  assign eol          = pixel_accept & (raw_x_q == cfg_w_q - W_BITS'(1));
  assign eof          = eol & (y_q == cfg_h_q - H_BITS'(1));
  assign sof          = pixel_accept & (raw_x_q == '0) & (y_q == '0);

  always_comb begin
    state_d     = state_q;
    seen_low_d  = seen_low_q;
    stop_pend_d = stop_pend_q;
    raw_x_d     = raw_x_q;
    y_d         = y_q;
    cfg_w_d     = cfg_w_q;
    cfg_h_d     = cfg_h_q;
    last_w_d    = last_w_q;
    last_h_d    = last_h_q;
    fcnt_d      = fcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_ARMED;
          cfg_w_d    = cfg_width;
          cfg_h_d    = cfg_height;
          seen_low_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          if (!frame_valid) seen_low_d = 1'b1;
          // Only a rising frame after an observed low is a clean frame start.
          if (seen_low_q && frame_valid) begin
            state_d = ST_CAPTURE;
            raw_x_d = '0;
            y_d     = '0;
          end
        end
      end
      ST_CAPTURE: begin
        if (stop) stop_pend_d = 1'b1;
        if (line_end) begin
          if (raw_x_q != '0) begin
            if (y_q != '1) y_d = y_q + H_BITS'(1);
            last_w_d = raw_x_q;
          end
          raw_x_d = '0;
        end else if (qual && raw_x_q != '1) begin
          raw_x_d = raw_x_q + W_BITS'(1);
        end
        if (frame_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (stop) stop_pend_d = 1'b1;
        fcnt_d     = fcnt_q + 16'd1;
        last_h_d   = y_q;
        seen_low_d = 1'b1;
        state_d    = (continuous && !stop_pend_q && !stop) ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) stop_pend_d = 1'b0;
  end

  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      seen_low_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      raw_x_q     <= '0;
      y_q         <= '0;
      cfg_w_q     <= '0;
      cfg_h_q     <= '0;
      last_w_q    <= '0;
      last_h_q    <= '0;
      fcnt_q      <= '0;
      lv_dly_q    <= 1'b0;
      fv_dly_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_low_q  <= seen_low_d;
      stop_pend_q <= stop_pend_d;
      raw_x_q     <= raw_x_d;
      y_q         <= y_d;
      cfg_w_q     <= cfg_w_d;
      cfg_h_q     <= cfg_h_d;
      last_w_q    <= last_w_d;
      last_h_q    <= last_h_d;
      fcnt_q      <= fcnt_d;
      lv_dly_q    <= line_valid;
      fv_dly_q    <= frame_valid;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = (state_q == ST_DONE);
  assign frame_count = fcnt_q;
  assign last_width  = last_w_q;
  assign last_height = last_h_q;
  assign dbg_state   = state_q;

`ifdef MT9V034_CAPTURE_ERR_EN
  logic err_s_q, err_s_d, err_l_q, err_l_d, err_h_q, err_h_d;

  always_comb begin
    err_s_d = err_s_q;
    err_l_d = err_l_q;
    err_h_d = err_h_q;
    if (start_ok) begin
      err_s_d = 1'b0;
      err_l_d = 1'b0;
      err_h_d = 1'b0;
    end else begin
      if (line_end && raw_x_q != '0) begin
        if (raw_x_q < cfg_w_q) err_s_d = 1'b1;
        if (raw_x_q > cfg_w_q) err_l_d = 1'b1;
      end
      // y_d already includes a line end landing in the same cycle.
      if (frame_end && y_d != cfg_h_q) err_h_d = 1'b1;
    end
  end

  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      err_s_q <= 1'b0;
      err_l_q <= 1'b0;
      err_h_q <= 1'b0;
    end else begin
      err_s_q <= err_s_d;
      err_l_q <= err_l_d;
      err_h_q <= err_h_d;
    end
  end

  assign err_short_line = err_s_q;
  assign err_long_line  = err_l_q;
  assign err_height     = err_h_q;
`else
  assign err_short_line = 1'b0;
  assign err_long_line  = 1'b0;
  assign err_height     = 1'b0;
`endif

endmodule

// File: tb/tb_mt9v034_capture_ctrl.sv
`timescale 1ns/1ps
module tb_mt9v034_capture_ctrl;
  localparam int WB = 10;
  localparam int HB = 10;

  // ---------------- clock / reset / DUT ----------------
  logic          pxclk = 1'b0;
  logic          reset_n, start, stop, continuous;
  logic [WB-1:0] cfg_width;
  logic [HB-1:0] cfg_height;
  logic          line_valid, frame_valid, active_video, pixel_data_valid;
  logic          pixel_accept, sof, eol, eof, busy, frame_done;
  logic [15:0]   frame_count;
  logic [WB-1:0] last_width;
  logic [HB-1:0] last_height;
  logic          err_short_line, err_long_line, err_height;
  logic [1:0]    dbg_state;

  always #5 pxclk = ~pxclk;

  mt9v034_capture_ctrl #(.W_BITS(WB), .H_BITS(HB)) dut (
    .pxclk(pxclk), .reset_n(reset_n), .start(start), .stop(stop),
    .continuous(continuous), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .line_valid(line_valid), .frame_valid(frame_valid),
    .active_video(active_video), .pixel_data_valid(pixel_data_valid),
    .pixel_accept(pixel_accept), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .last_width(last_width), .last_height(last_height),
    .err_short_line(err_short_line), .err_long_line(err_long_line),
    .err_height(err_height), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];   // {pixel_accept, sof, eol, eof, frame_done} per cycle
  logic fd_next = 1'b0;
  int acc_cnt, sof_cnt, eol_cnt, eof_cnt;

  // frame-level model
  int m_cw, m_ch;
  int m_count, m_lw, m_lh;
  bit m_es, m_el, m_eh;
  int len[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic lv, fv, av, pdv, st, sp,
                      input logic a, s, el, ef);
    @(posedge pxclk); #1;
    line_valid       = lv;
    frame_valid      = fv;
    active_video     = av;
    pixel_data_valid = pdv;
    start            = st;
    stop             = sp;
    exp_q.push_back({a, s, el, ef, fd_next});
    fd_next = 1'b0;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_counts();
    acc_cnt = 0; sof_cnt = 0; eol_cnt = 0; eof_cnt = 0;
  endtask

  task automatic check_stats(input bit exp_busy);
    chk("frame_count", frame_count, m_count);
    chk("last_width", last_width, m_lw);
    chk("last_height", last_height, m_lh);
    chk("busy", busy, exp_busy);
`ifdef MT9V034_CAPTURE_ERR_EN
    chk("err_short_line", err_short_line, m_es);
    chk("err_long_line", err_long_line, m_el);
    chk("err_height", err_height, m_eh);
`else
    chk("err_short_line", err_short_line, 0);
    chk("err_long_line", err_long_line, 0);
    chk("err_height", err_height, 0);
`endif
  endtask

  task automatic arm(input int w, input int h, input bit cont);
    m_cw = w; m_ch = h;
    cfg_width  = WB'(w);
    cfg_height = HB'(h);
    continuous = cont;
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    m_es = 0; m_el = 0; m_eh = 0;
    idle_step();
    idle_step();
  endtask

  // Sends one frame of nl lines with lengths len[]. cap says whether the
  // frame is expected to be captured; st_line/sp_line pulse start/stop on
  // the first pixel of that line (-1 = never).
  task automatic send_frame(input int nl, input bit cap, input int st_line,
                            input int sp_line, input bit exp_busy);
    int pre, gap;
    bit dropped;
    bit a;
    dropped = 0;
    pre = 2 + $urandom_range(0, 2);
    for (int i = 0; i < pre; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      for (int c = 0; c < len[l]; c++) begin
        while ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 1) step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
          else                           step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        a = cap && (c < m_cw) && (l < m_ch);
        step(1, 1, 1, 1, (c == 0 && l == st_line), (c == 0 && l == sp_line),
             a, a && c == 0 && l == 0, a && c == m_cw - 1,
             a && c == m_cw - 1 && l == m_ch - 1);
      end
      if (l == nl - 1 && $urandom_range(0, 1) == 1) begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // line and frame drop together
        dropped = 1;
      end else begin
        gap = 1 + $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      end
    end
    if (!dropped) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (st_line >= 0) begin
      m_es = 0; m_el = 0; m_eh = 0;
    end
    fd_next = cap;
    idle_step();   // DONE cycle
    idle_step();
    if (cap) begin
      m_count = (m_count + 1) % 65536;
      m_lw = len[nl - 1];
      m_lh = nl;
      for (int l = 0; l < nl; l++) begin
        if (len[l] < m_cw) m_es = 1;
        if (len[l] > m_cw) m_el = 1;
      end
      if (nl != m_ch) m_eh = 1;
    end
    @(negedge pxclk);
    check_stats(exp_busy);
  endtask

  // ---------------- compare process ----------------
  always @(negedge pxclk) begin
    logic [4:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("markers", {pixel_accept, sof, eol, eof, frame_done}, e);
      acc_cnt += pixel_accept;
      sof_cnt += sof;
      eol_cnt += eol;
      eof_cnt += eof;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w, h, nf, nl;
    bit cont;
    reset_n = 0; start = 0; stop = 0; continuous = 0;
    cfg_width = '0; cfg_height = '0;
    line_valid = 0; frame_valid = 0; active_video = 0; pixel_data_valid = 0;
    m_count = 0; m_lw = 0; m_lh = 0; m_es = 0; m_el = 0; m_eh = 0;
    m_cw = 0; m_ch = 0;
    clr_counts();
    repeat (3) @(posedge pxclk);
    #1 reset_n = 1;
    @(negedge pxclk);
    chk("rst_state", dbg_state, 0);
    chk("rst_accept", pixel_accept, 0);
    chk("rst_frame_done", frame_done, 0);
    check_stats(0);

    // nominal single-shot 4x3
    arm(4, 3, 0);
    for (int l = 0; l < 3; l++) len[l] = 4;
    clr_counts();
    send_frame(3, 1, -1, -1, 0);
    chk("nom_accepts", acc_cnt, 12);
    chk("nom_sof", sof_cnt, 1);
    chk("nom_eol", eol_cnt, 3);
    chk("nom_eof", eof_cnt, 1);
    chk("nom_count", frame_count, 1);
    chk("nom_width", last_width, 4);
    chk("nom_height", last_height, 3);

    // arming mid-frame: that frame is skipped, the next one captured
    clr_counts();
    send_frame(3, 0, 1, -1, 1);
    chk("mid_skip_accepts", acc_cnt, 0);
    clr_counts();
    send_frame(3, 1, -1, -1, 0);
    chk("mid_accepts", acc_cnt, 12);
    chk("mid_count", frame_count, 2);

    // oversize frame 4 lines x 6 px, cropped to 4x3
    arm(4, 3, 0);
    for (int l = 0; l < 4; l++) len[l] = 6;
    clr_counts();
    send_frame(4, 1, -1, -1, 0);
    chk("over_accepts", acc_cnt, 12);
    chk("over_eof", eof_cnt, 1);
    chk("over_width", last_width, 6);
    chk("over_height", last_height, 4);

    // short middle line
    arm(4, 3, 0);
    len[0] = 4; len[1] = 3; len[2] = 4;
    clr_counts();
    send_frame(3, 1, -1, -1, 0);
    chk("short_accepts", acc_cnt, 11);
    chk("short_eol", eol_cnt, 2);
    chk("short_eof", eof_cnt, 1);

    // continuous, stop during frame 2, frame 3 ignored
    arm(4, 3, 1);
    for (int l = 0; l < 3; l++) len[l] = 4;
    send_frame(3, 1, -1, -1, 1);
    send_frame(3, 1, -1, 1, 0);
    chk("cont_count", frame_count, 6);
    continuous = 0;
    clr_counts();
    send_frame(3, 0, -1, -1, 0);
    chk("cont_f3_accepts", acc_cnt, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle_step();
    @(negedge pxclk);
    chk("start_stop_busy", busy, 0);

    // reset mid-frame
    arm(4, 3, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    reset_n = 0;
    @(negedge pxclk);
    chk("rstmid_accept", pixel_accept, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_state", dbg_state, 0);
    chk("rstmid_count", frame_count, 0);
    chk("rstmid_width", last_width, 0);
    chk("rstmid_height", last_height, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    reset_n = 1;
    m_count = 0; m_lw = 0; m_lh = 0; m_es = 0; m_el = 0; m_eh = 0;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 4; c++) step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    idle_step();
    idle_step();
    idle_step();
    @(negedge pxclk);
    check_stats(0);

    // randomized geometry, single-shot and continuous
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      cont = ($urandom_range(0, 1) == 1);
      nf = cont ? 2 : 1;
      arm(w, h, cont);
      for (int f = 0; f < nf; f++) begin
        nl = h + $urandom_range(0, 2) - 1;
        if (nl < 1) nl = 1;
        for (int l = 0; l < nl; l++) begin
          len[l] = w + $urandom_range(0, 2) - 1;
          if (len[l] < 1) len[l] = 1;
        end
        send_frame(nl, 1, -1, (cont && f == 1) ? 0 : -1, cont && f == 0);
      end
      continuous = 0;
    end

    idle_step();
    idle_step();
    @(negedge pxclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
